// File: rtl/q_tables_pkg.sv
// -----------------------------------------------------------------------------
// q_tables_pkg
// Shared definitions for the Q-learning table storage bank: default table
// geometry, the goal reward location and value, action encodings and the
// address typedefs used to build Q-table addresses from {state, action}.
// -----------------------------------------------------------------------------
package q_tables_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

  localparam int DEF_GOAL_STATE  = 63;
  localparam int DEF_GOAL_REWARD = 100;

  localparam int STATE_WIDTH  = 6;
  localparam int ACTION_WIDTH = 2;

  typedef enum logic [ACTION_WIDTH-1:0] {
    ACT_LEFT  = 2'b00,
    ACT_UP    = 2'b01,
    ACT_RIGHT = 2'b10,
    ACT_DOWN  = 2'b11
  } action_e;

  typedef logic [STATE_WIDTH-1:0]    state_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  // Q-table address for a (state, action) pair.
  function automatic addr_t q_addr(input state_t state, input action_e action);
    return {state, action};
  endfunction

endpackage : q_tables_pkg

// File: rtl/q_table_ram.sv
// -----------------------------------------------------------------------------
// q_table_ram
// Simple dual-port RAM (one write port, one read port) with a registered read
// output, used for both the Q and the Qmax tables.
//
// Configuration macro: RAW_BYPASS_EN
//   undefined : read-first; a same-address read on a write edge returns the
//               old contents.
//   defined   : write-first; the incoming write data is forwarded to the
//               output register when write and read addresses match.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (clears the output register only)
//   i_addr_r    read address
//   i_addr_w    write address
//   i_write_en  write strobe
//   i_data      write data
//   o_data      registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module q_table_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr_r,
  input  logic [ADDR_WIDTH-1:0] i_addr_w,
  input  logic                  i_write_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_fire;

  // Writes are suppressed while reset is asserted so that a write landing on
  // the reset edge cannot corrupt stored data.
  assign wr_fire = i_write_en & i_rst_n;

  // NOTE: the storage array has no reset branch; a reset would prevent block
  // RAM inference and the contents must survive reset anyway.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem_q[i_addr_w] <= i_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_data_d = mem_q[i_addr_r];
`ifdef RAW_BYPASS_EN
    if (wr_fire && (i_addr_w == i_addr_r)) begin
      rd_data_d = i_data;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_data = rd_data_q;

endmodule : q_table_ram

// File: rtl/q_tables.sv
// -----------------------------------------------------------------------------
// q_tables
// Storage bank for the Q-learning accelerator: Q table and Qmax table
// (read/write, 1-cycle registered reads) plus a read-only reward (R) table
// that is zero everywhere except GOAL_STATE, which holds GOAL_REWARD.
// The three tables are fully independent and may all be accessed each cycle.
//
// Configuration macro: RAW_BYPASS_EN (write-first forwarding on Q and Qmax;
// the R table is unaffected).
//
// Ports:
//   i_clk, i_rst_n                   clock / asynchronous active-low reset
//   i_q_addr_r, i_q_addr_w           Q read / write address
//   i_q_write_en, i_q_data           Q write strobe / data
//   o_q_data                         Q read data
//   i_qmax_addr_r, i_qmax_addr_w     Qmax read / write address
//   i_qmax_write_en, i_qmax_data     Qmax write strobe / data
//   o_qmax_data                      Qmax read data
//   i_r_addr, i_r_read               R read address / read enable
//   o_r_data                         R read data (holds when i_r_read = 0)
// -----------------------------------------------------------------------------
module q_tables
  import q_tables_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int GOAL_STATE  = DEF_GOAL_STATE,
  parameter int GOAL_REWARD = DEF_GOAL_REWARD
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_q_addr_r,
  input  logic [ADDR_WIDTH-1:0] i_q_addr_w,
  input  logic                  i_q_write_en,
  input  logic [DATA_WIDTH-1:0] i_q_data,
  output logic [DATA_WIDTH-1:0] o_q_data,
  input  logic [ADDR_WIDTH-1:0] i_qmax_addr_r,
  input  logic [ADDR_WIDTH-1:0] i_qmax_addr_w,
  input  logic                  i_qmax_write_en,
  input  logic [DATA_WIDTH-1:0] i_qmax_data,
  output logic [DATA_WIDTH-1:0] o_qmax_data,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  input  logic                  i_r_read,
  output logic [DATA_WIDTH-1:0] o_r_data
);

  q_table_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_q_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_addr_r  (i_q_addr_r),
    .i_addr_w  (i_q_addr_w),
    .i_write_en(i_q_write_en),
    .i_data    (i_q_data),
    .o_data    (o_q_data)
  );

  q_table_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_qmax_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_addr_r  (i_qmax_addr_r),
    .i_addr_w  (i_qmax_addr_w),
    .i_write_en(i_qmax_write_en),
    .i_data    (i_qmax_data),
    .o_data    (o_qmax_data)
  );

  // Reward ROM: a single non-zero entry, so it collapses to an address compare.
  function automatic logic [DATA_WIDTH-1:0] r_rom(input logic [ADDR_WIDTH-1:0] addr);
    return (addr == ADDR_WIDTH'(GOAL_STATE)) ? DATA_WIDTH'(GOAL_REWARD) : '0;
  endfunction

  logic [DATA_WIDTH-1:0] r_data_d;
  logic [DATA_WIDTH-1:0] r_data_q;

  always_comb begin
    r_data_d = r_data_q;
    if (i_r_read) begin
      r_data_d = r_rom(i_r_addr);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign o_r_data = r_data_q;

endmodule : q_tables

// File: tb/tb_q_tables.sv
// -----------------------------------------------------------------------------
// tb_q_tables
// Directed, table-driven bench for q_tables. Each vector is one clock cycle of
// inputs plus the outputs expected just after that rising edge. Reset and
// reset-during-write behaviour are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_q_tables;

`ifdef RAW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] q_addr_r, q_addr_w, q_data_in;
  logic       q_we;
  logic [7:0] qm_addr_r, qm_addr_w, qm_data_in;
  logic       qm_we;
  logic [7:0] r_addr;
  logic       r_rd;
  logic [7:0] q_out, qm_out, r_out;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  q_tables dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_q_addr_r     (q_addr_r),
    .i_q_addr_w     (q_addr_w),
    .i_q_write_en   (q_we),
    .i_q_data       (q_data_in),
    .o_q_data       (q_out),
    .i_qmax_addr_r  (qm_addr_r),
    .i_qmax_addr_w  (qm_addr_w),
    .i_qmax_write_en(qm_we),
    .i_qmax_data    (qm_data_in),
    .o_qmax_data    (qm_out),
    .i_r_addr       (r_addr),
    .i_r_read       (r_rd),
    .o_r_data       (r_out)
  );

  typedef struct {
    string      name;
    logic [7:0] q_ar, q_aw, q_d;
    logic       q_we;
    logic [7:0] qm_ar, qm_aw, qm_d;
    logic       qm_we;
    logic [7:0] r_a;
    logic       r_rd;
    logic [7:0] exp_q, exp_qm, exp_r;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string name,
    input logic [7:0] q_ar, input logic q_we, input logic [7:0] q_aw, input logic [7:0] q_d,
    input logic [7:0] qm_ar, input logic qm_we, input logic [7:0] qm_aw, input logic [7:0] qm_d,
    input logic r_rd, input logic [7:0] r_a,
    input logic [7:0] exp_q, input logic [7:0] exp_qm, input logic [7:0] exp_r);
    vec_t v;
    v.name = name;
    v.q_ar = q_ar;   v.q_we = q_we;   v.q_aw = q_aw;   v.q_d = q_d;
    v.qm_ar = qm_ar; v.qm_we = qm_we; v.qm_aw = qm_aw; v.qm_d = qm_d;
    v.r_rd = r_rd;   v.r_a = r_a;
    v.exp_q = exp_q; v.exp_qm = exp_qm; v.exp_r = exp_r;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    q_addr_r = 8'h00;  q_addr_w = 8'h00;  q_we = 1'b0;  q_data_in = 8'h00;
    qm_addr_r = 8'h00; qm_addr_w = 8'h00; qm_we = 1'b0; qm_data_in = 8'h00;
    r_addr = 8'h00;    r_rd = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    q_addr_r = v.q_ar;   q_we = v.q_we;   q_addr_w = v.q_aw;   q_data_in = v.q_d;
    qm_addr_r = v.qm_ar; qm_we = v.qm_we; qm_addr_w = v.qm_aw; qm_data_in = v.qm_d;
    r_addr = v.r_a;      r_rd = v.r_rd;
    @(posedge clk);
    #1;
    check({v.name, ".q"},    q_out,  v.exp_q);
    check({v.name, ".qmax"}, qm_out, v.exp_qm);
    check({v.name, ".r"},    r_out,  v.exp_r);
  endtask

  initial begin
    idle_inputs();

    // ---------------- reset state ----------------
    #12;
    check("reset.q",    q_out,  8'h00);
    check("reset.qmax", qm_out, 8'h00);
    check("reset.r",    r_out,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- vector table ----------------
    //                name              q_ar  we  q_aw  q_d    qm_ar we  qm_aw qm_d   rd  r_a    exp_q exp_qm exp_r
    vecs.push_back(mk("wr_q_1b",        8'h00, 1, 8'h1B, 8'h37, 8'h1B, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("rd_q_1b",        8'h1B, 0, 8'h00, 8'h00, 8'h1B, 0, 8'h00, 8'h00, 0, 8'h00, 8'h37, 8'h00, 8'h00));
    vecs.push_back(mk("qmax_raw_ff",    8'h1B, 0, 8'h00, 8'h00, 8'hFF, 1, 8'hFF, 8'hA5, 0, 8'h00, 8'h37, BYP ? 8'hA5 : 8'h00, 8'h00));
    vecs.push_back(mk("qmax_rd_ff",     8'h1B, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 0, 8'h00, 8'h37, 8'hA5, 8'h00));
    vecs.push_back(mk("r_goal",         8'h1B, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 1, 8'd63,  8'h37, 8'hA5, 8'h64));
    vecs.push_back(mk("r_addr5",        8'h1B, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 1, 8'd5,   8'h37, 8'hA5, 8'h00));
    vecs.push_back(mk("r_hold",         8'h1B, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 0, 8'd63,  8'h37, 8'hA5, 8'h00));
    vecs.push_back(mk("r_hi_addr",      8'h1B, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 1, 8'hBF,  8'h37, 8'hA5, 8'h00));
    vecs.push_back(mk("concurrent",     8'h02, 1, 8'h02, 8'h10, 8'h08, 1, 8'h08, 8'h20, 1, 8'd63,  BYP ? 8'h10 : 8'h00, BYP ? 8'h20 : 8'h00, 8'h64));
    vecs.push_back(mk("concurrent_rd",  8'h02, 0, 8'h00, 8'h00, 8'h08, 0, 8'h00, 8'h00, 0, 8'h00,  8'h10, 8'h20, 8'h64));
    vecs.push_back(mk("isolation",      8'h08, 0, 8'h00, 8'h00, 8'h02, 0, 8'h00, 8'h00, 0, 8'h00,  8'h00, 8'h00, 8'h64));
    vecs.push_back(mk("b2b_wr1",        8'h1B, 1, 8'h00, 8'h01, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00,  8'h37, 8'h00, 8'h64));
    vecs.push_back(mk("b2b_wr2",        8'h1B, 1, 8'h00, 8'h02, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00,  8'h37, 8'h00, 8'h64));
    vecs.push_back(mk("b2b_wr3_raw",    8'h00, 1, 8'h00, 8'h03, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00,  BYP ? 8'h03 : 8'h02, 8'h00, 8'h64));
    vecs.push_back(mk("b2b_final",      8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00,  8'h03, 8'h00, 8'h64));
    vecs.push_back(mk("wr_q_ff",        8'h00, 1, 8'hFF, 8'h5A, 8'hFF, 0, 8'h00, 8'h00, 0, 8'h00,  8'h03, 8'hA5, 8'h64));
    vecs.push_back(mk("rd_q_ff",        8'hFF, 0, 8'h00, 8'h00, 8'h1B, 0, 8'h00, 8'h00, 0, 8'h00,  8'h5A, 8'h00, 8'h64));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // ---------------- async reset mid-run ----------------
    // Make all three outputs nonzero first.
    q_addr_r = 8'h1B; q_we = 1'b0; qm_addr_r = 8'hFF; qm_we = 1'b0;
    r_addr = 8'd63;   r_rd = 1'b1;
    @(posedge clk); #1;
    check("pre_rst.q",    q_out,  8'h37);
    check("pre_rst.qmax", qm_out, 8'hA5);
    check("pre_rst.r",    r_out,  8'h64);

    // Assert reset between edges: outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.q",    q_out,  8'h00);
    check("async_rst.qmax", qm_out, 8'h00);
    check("async_rst.r",    r_out,  8'h00);

    // A write presented while reset is held must be dropped, outputs stay 0.
    q_we = 1'b1; q_addr_w = 8'h1B; q_data_in = 8'hEE;
    qm_we = 1'b1; qm_addr_w = 8'hFF; qm_data_in = 8'h11;
    @(posedge clk); #1;
    check("in_rst.q",    q_out,  8'h00);
    check("in_rst.qmax", qm_out, 8'h00);
    check("in_rst.r",    r_out,  8'h00);
    q_we = 1'b0; qm_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First reads after release return the preserved contents.
    @(posedge clk); #1;
    check("post_rst.q",    q_out,  8'h37);
    check("post_rst.qmax", qm_out, 8'hA5);
    check("post_rst.r",    r_out,  8'h64);

    // R holds its value once the read enable drops.
    r_rd = 1'b0; r_addr = 8'd5;
    @(posedge clk); #1;
    check("post_rst.r_hold", r_out, 8'h64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_q_tables
